clint_initiator: RTL and testbench

CLINT_INITIATOR -- requirements
Module: clint_initiator

---
 rtl/clint_pkg.sv | 17 +
 rtl/clint_bus_xfer.sv | 43 ++++
 rtl/clint_initiator.sv | 184 ++++++++++++++++++
 tb/tb_clint_initiator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: CLINT address map, command encoding and initiator FSM states.
package clint_pkg;
  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_LO_ADDR = 16'hBFF8;
  localparam logic [15:0] MTIME_HI_ADDR = 16'hBFFC;
  typedef enum logic [1:0] {
    OP_SET_MSIP   = 2'd0,
    OP_CLR_MSIP   = 2'd1,
    OP_ARM_TIMER  = 2'd2,
    OP_READ_MTIME = 2'd3
  } op_e;
  typedef enum logic [3:0] {
    S_IDLE, S_MSIP_WR, S_RD_HI1, S_RD_LO, S_RD_HI2,
    S_CMP_HI_MAX, S_CMP_LO, S_CMP_HI, S_DONE
  } state_e;
endpackage

// File: rtl/clint_bus_xfer.sv
// clint_bus_xfer: one CLINT bus access; request is latched on i_start and held until ready.
module clint_bus_xfer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  output logic                o_done,
  output logic                o_valid,
  output logic [ADDR_W-1:0]   o_address,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_wstrb,
  input  logic                i_ready
);
  logic                r_valid;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_valid   <= 1'b0;
      r_address <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (i_start) begin
      r_valid   <= 1'b1;
      r_address <= i_addr;
      r_wdata   <= i_wdata;
      r_wstrb   <= i_wstrb;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  // Combinational completion lets the FSM restart on the next edge, giving a one-cycle valid gap.
  assign o_done    = r_valid && i_ready;
  assign o_valid   = r_valid;
  assign o_address = r_address;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
endmodule

// File: rtl/clint_initiator.sv
// clint_initiator: turns MSIP / timer-arm / mtime-read commands into CLINT bus accesses.
module clint_initiator
  import clint_pkg::*;
#(
  parameter  int ADDR_W  = 16,
  parameter  int DATA_W  = 32,
  parameter  int N_CORES = 1,
  localparam int HW      = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [HW-1:0]       cmd_hart,
  input  logic [63:0]         cmd_delta,
  output logic                rsp_valid,
  output logic [63:0]         rsp_data,
  output logic                busy,
  output logic                valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready
);
  state_e              r_state;
  op_e                 r_op;
  logic [HW-1:0]       r_hart;
  logic [63:0]         r_delta;
  logic [63:0]         r_target;
  logic [DATA_W-1:0]   r_hi1;
  logic [DATA_W-1:0]   r_lo;
  logic                r_start;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [63:0]         r_rsp_data;
  logic                w_done;
  logic                w_bad_hart;
  logic [63:0]         w_mtime;
  logic [ADDR_W-1:0]   w_msip;
  logic [ADDR_W-1:0]   w_cmp_lo;
  logic [ADDR_W-1:0]   w_cmp_hi;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_wstrb;
  assign w_bad_hart = 32'(cmd_hart) >= 32'(N_CORES);
  assign w_mtime    = {r_hi1, r_lo};
  assign w_msip     = ADDR_W'(MSIP_BASE) + (ADDR_W'(r_hart) << 2);
  assign w_cmp_lo   = ADDR_W'(MTIMECMP_BASE) + (ADDR_W'(r_hart) << 3);
  assign w_cmp_hi   = w_cmp_lo + ADDR_W'(4);
  always_comb begin
    w_addr  = w_cmp_hi;
    w_wdata = '0;
    w_wstrb = '0;
    case (r_state)
      S_MSIP_WR: begin
        w_addr  = w_msip;
        w_wdata = DATA_W'(r_op == OP_SET_MSIP);
        w_wstrb = '1;
      end
      S_RD_HI1, S_RD_HI2: w_addr = ADDR_W'(MTIME_HI_ADDR);
      S_RD_LO:            w_addr = ADDR_W'(MTIME_LO_ADDR);
      S_CMP_HI_MAX: begin
        w_wdata = '1;
        w_wstrb = '1;
      end
      S_CMP_LO: begin
        w_addr  = w_cmp_lo;
        w_wdata = r_target[DATA_W-1:0];
        w_wstrb = '1;
      end
      S_CMP_HI: begin
        w_wdata = r_target[2*DATA_W-1:DATA_W];
        w_wstrb = '1;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= S_IDLE;
      r_op        <= OP_SET_MSIP;
      r_hart      <= '0;
      r_delta     <= '0;
      r_target    <= '0;
      r_hi1       <= '0;
      r_lo        <= '0;
      r_start     <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_op        <= op_e'(cmd_op);
            r_hart      <= cmd_hart;
            r_delta     <= cmd_delta;
            r_cmd_ready <= 1'b0;
            if (w_bad_hart) begin
              r_state     <= S_DONE;
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= '1;
            end else begin
              // op[1] selects the mtime-based commands (ARM_TIMER, READ_MTIME)
              r_state <= cmd_op[1] ? S_RD_HI1 : S_MSIP_WR;
              r_start <= 1'b1;
            end
          end
        end
        S_MSIP_WR: if (w_done) begin
          r_state     <= S_DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= 64'(r_op == OP_SET_MSIP);
        end
        S_RD_HI1: if (w_done) begin
          r_hi1   <= rdata;
          r_state <= S_RD_LO;
          r_start <= 1'b1;
        end
        S_RD_LO: if (w_done) begin
          r_lo    <= rdata;
          r_state <= S_RD_HI2;
          r_start <= 1'b1;
        end
        S_RD_HI2: if (w_done) begin
          if (rdata != r_hi1) begin
            r_hi1   <= rdata;
            r_state <= S_RD_LO;
            r_start <= 1'b1;
          end else if (r_op == OP_READ_MTIME) begin
            r_state     <= S_DONE;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_mtime;
          end else begin
            r_target <= w_mtime + r_delta;
            r_state  <= S_CMP_HI_MAX;
            r_start  <= 1'b1;
          end
        end
        // Parking MTIMECMP_HI at all-ones first keeps a half-written compare from firing early.
        S_CMP_HI_MAX: if (w_done) begin
          r_state <= S_CMP_LO;
          r_start <= 1'b1;
        end
        S_CMP_LO: if (w_done) begin
          r_state <= S_CMP_HI;
          r_start <= 1'b1;
        end
        S_CMP_HI: if (w_done) begin
          r_state     <= S_DONE;
          r_rsp_valid <= 1'b1;
          r_rsp_data  <= r_target;
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_state != S_IDLE;
  clint_bus_xfer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_xfer (
    .clk      (clk),
    .reset    (reset),
    .i_start  (r_start),
    .i_addr   (w_addr),
    .i_wdata  (w_wdata),
    .i_wstrb  (w_wstrb),
    .o_done   (w_done),
    .o_valid  (valid),
    .o_address(address),
    .o_wdata  (wdata),
    .o_wstrb  (wstrb),
    .i_ready  (ready)
  );
endmodule

// File: tb/tb_clint_initiator.sv
// tb_clint_initiator: directed self-checking bench with an inline bus responder.
module tb_clint_initiator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [1:0]  cmd_hart = 2'd0;
  logic [63:0] cmd_delta = '0;
  logic        cmd_ready, rsp_valid, busy, valid;
  logic [63:0] rsp_data;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata = '0;
  logic [3:0]  wstrb;
  logic        ready = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] rd_q[$];
  logic [15:0] a_addr[$];
  logic [31:0] a_wdata[$];
  logic [3:0]  a_wstrb[$];
  int          rsp_cnt, extra_acc, bad_gap, rst_rsp, rst_acc;
  logic [63:0] rsp_got;
  logic        rdy_after, busy_after;
  always #5 clk = ~clk;
  clint_initiator #(.ADDR_W(16), .DATA_W(32), .N_CORES(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_hart(cmd_hart), .cmd_delta(cmd_delta),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Issues one command, answers each access after lat cycles, optionally pokes cmd_valid mid-flight.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] hart, input logic [63:0] delta,
                         input int lat, input int poke);
    int  wcnt = 0;
    int  low = -1;
    bit  got = 0;
    a_addr.delete();
    a_wdata.delete();
    a_wstrb.delete();
    rsp_cnt = 0;
    extra_acc = 0;
    bad_gap = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_hart = hart;
    cmd_delta = delta;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      cmd_valid = (c == poke);
      if (ready) begin
        ready = 1'b0;
        low = valid ? 0 : 1;
      end else if (valid) begin
        if (low >= 0 && low != 1) bad_gap++;
        low = -1;
        if (wcnt == lat) begin
          ready = 1'b1;
          a_addr.push_back(address);
          a_wdata.push_back(wdata);
          a_wstrb.push_back(wstrb);
          rdata = (wstrb == 4'h0 && rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
          wcnt = 0;
        end else wcnt++;
      end else if (low >= 0) low++;
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_got = rsp_data;
        got = 1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    ready = 1'b0;
    rdy_after = cmd_ready;
    busy_after = busy;
    for (int t = 0; t < 4; t++) begin
      if (valid) extra_acc++;
      if (rsp_valid) rsp_cnt++;
      @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] e_addr[5];
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_bus", {address, wdata, wstrb}, 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("rel_cmd_ready_pre", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1 check("rel_cmd_ready_post", 64'(cmd_ready), 64'd1);
    // SET_MSIP hart 0, ready after 2 cycles
    run_cmd(2'd0, 2'd0, 64'd0, 2, -1);
    check("set_nacc", 64'(a_addr.size()), 64'd1);
    check("set_addr", 64'(a_addr[0]), 64'h0);
    check("set_wdata", 64'(a_wdata[0]), 64'd1);
    check("set_wstrb", 64'(a_wstrb[0]), 64'hF);
    check("set_rsp_cnt", 64'(rsp_cnt), 64'd1);
    check("set_rsp", rsp_got, 64'd1);
    check("set_ready_after", 64'(rdy_after), 64'd1);
    check("set_busy_after", 64'(busy_after), 64'd0);
    // CLR_MSIP hart 2
    run_cmd(2'd1, 2'd2, 64'd0, 0, -1);
    check("clr_nacc", 64'(a_addr.size()), 64'd1);
    check("clr_addr", 64'(a_addr[0]), 64'h8);
    check("clr_wdata", 64'(a_wdata[0]), 64'd0);
    check("clr_wstrb", 64'(a_wstrb[0]), 64'hF);
    check("clr_rsp", rsp_got, 64'd0);
    // READ_MTIME consistent first pass
    rd_q = '{32'h5, 32'h10, 32'h5};
    run_cmd(2'd3, 2'd0, 64'd0, 1, -1);
    check("rd_nacc", 64'(a_addr.size()), 64'd3);
    check("rd_addrs", {16'h0, a_addr[0], a_addr[1], a_addr[2]}, 64'h0000_BFFC_BFF8_BFFC);
    check("rd_wstrbs", {52'h0, a_wstrb[0], a_wstrb[1], a_wstrb[2]}, 64'h0);
    check("rd_rsp", rsp_got, 64'h0000_0005_0000_0010);
    check("rd_gap", 64'(bad_gap), 64'd0);
    // READ_MTIME with hi rollover between reads
    rd_q = '{32'h5, 32'h10, 32'h6, 32'h20, 32'h6};
    e_addr = '{16'hBFFC, 16'hBFF8, 16'hBFFC, 16'hBFF8, 16'hBFFC};
    run_cmd(2'd3, 2'd0, 64'd0, 0, -1);
    check("retry_nacc", 64'(a_addr.size()), 64'd5);
    for (int i = 0; i < 5; i++) check($sformatf("retry_addr%0d", i), 64'(a_addr[i]), 64'(e_addr[i]));
    check("retry_rsp", rsp_got, 64'h0000_0006_0000_0020);
    check("retry_gap", 64'(bad_gap), 64'd0);
    // ARM_TIMER with target wrapping past 2^64
    rd_q = '{32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFFF};
    run_cmd(2'd2, 2'd0, 64'h20, 0, -1);
    check("arm_nacc", 64'(a_addr.size()), 64'd6);
    check("arm_w0", {a_addr[3], a_wdata[3], 12'h0, a_wstrb[3]}, 64'h4004_FFFF_FFFF_000F);
    check("arm_w1", {a_addr[4], a_wdata[4], 12'h0, a_wstrb[4]}, 64'h4000_0000_0010_000F);
    check("arm_w2", {a_addr[5], a_wdata[5], 12'h0, a_wstrb[5]}, 64'h4004_0000_0000_000F);
    check("arm_rsp", rsp_got, 64'h10);
    check("arm_gap", 64'(bad_gap), 64'd0);
    // ARM_TIMER hart 2 with carry into the high word
    rd_q = '{32'h1, 32'hFFFF_FF80, 32'h1};
    run_cmd(2'd2, 2'd2, 64'h100, 1, -1);
    check("arm2_w0", {a_addr[3], a_wdata[3], 12'h0, a_wstrb[3]}, 64'h4014_FFFF_FFFF_000F);
    check("arm2_w1", {a_addr[4], a_wdata[4], 12'h0, a_wstrb[4]}, 64'h4010_0000_0080_000F);
    check("arm2_w2", {a_addr[5], a_wdata[5], 12'h0, a_wstrb[5]}, 64'h4014_0000_0002_000F);
    check("arm2_rsp", rsp_got, 64'h0000_0002_0000_0080);
    // Reset in the middle of an access
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'd0;
    cmd_hart = 2'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_valid_pre", 64'(valid), 64'd1);
    #2 reset = 1'b0;
    #1 check("mid_valid_async", 64'(valid), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_cmd_ready", 64'(cmd_ready), 64'd0);
    rst_rsp = 0;
    rst_acc = 0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      if (rsp_valid) rst_rsp++;
    end
    reset = 1'b1;
    #1 check("mid_ready_pre", 64'(cmd_ready), 64'd0);
    @(posedge clk);
    #1 check("mid_ready_post", 64'(cmd_ready), 64'd1);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (rsp_valid) rst_rsp++;
      if (valid) rst_acc++;
    end
    check("mid_no_rsp", 64'(rst_rsp), 64'd0);
    check("mid_no_acc", 64'(rst_acc), 64'd0);
    // Out-of-range hart
    run_cmd(2'd0, 2'd3, 64'd0, 0, -1);
    check("bad_nacc", 64'(a_addr.size()), 64'd0);
    check("bad_extra", 64'(extra_acc), 64'd0);
    check("bad_rsp_cnt", 64'(rsp_cnt), 64'd1);
    check("bad_rsp", rsp_got, 64'hFFFF_FFFF_FFFF_FFFF);
    // Command poked while busy must be dropped
    rd_q = '{32'h7, 32'h8, 32'h7};
    run_cmd(2'd3, 2'd0, 64'd0, 1, 3);
    check("poke_nacc", 64'(a_addr.size()), 64'd3);
    check("poke_rsp", rsp_got, 64'h0000_0007_0000_0008);
    check("poke_rsp_cnt", 64'(rsp_cnt), 64'd1);
    check("poke_extra", 64'(extra_acc), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
